// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared word types, arbiter state and owner encodings.
package mem_arbiter_pkg;
  typedef logic [31:0] u32;
  typedef logic [7:0] u8;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_arb_state_t;
  typedef enum logic {OWN_I, OWN_D} mem_owner_t;
  localparam u32 ABORT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instr fetch and data, data first with a starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  u32   i_addr,
  output logic i_ack,
  output u32   i_rdata,
  input  logic d_req,
  input  logic d_we,
  input  u32   d_addr,
  input  u32   d_wdata,
  output logic d_ack,
  output u32   d_rdata,
  output logic m_req,
  output logic m_we,
  output u32   m_addr,
  output u32   m_wdata,
  input  u32   m_rdata,
  input  logic m_ack,
  output logic err
);
  mem_arb_state_t state;
  mem_owner_t owner;
  u8 streak, timer;
  logic pick_i, done;
  u32 resp_data;
  always_comb begin
    pick_i = i_req && (!d_req || streak == u8'(MAX_D_STREAK));
    done = m_ack || timer == u8'(TIMEOUT);
    resp_data = m_ack ? m_rdata : ABORT_DATA;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_I;
      streak <= '0;
      timer <= '0;
      m_req <= 1'b0;
      m_we <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: if (i_req || d_req) begin
          state <= BUSY;
          owner <= pick_i ? OWN_I : OWN_D;
          m_req <= 1'b1;
          m_we <= !pick_i && d_we;
          m_addr <= pick_i ? i_addr : d_addr;
          m_wdata <= pick_i ? '0 : d_wdata;
          timer <= '0;
          // a data grant only extends the streak while the fetch is actually waiting
          streak <= (!pick_i && i_req) ? streak + u8'(streak != u8'(MAX_D_STREAK)) : '0;
        end
        BUSY: begin
          timer <= timer + 8'd1;
          if (done) begin
            state <= RESP;
            m_req <= 1'b0;
            err <= err | !m_ack;
            if (owner == OWN_I) begin
              i_ack <= 1'b1;
              i_rdata <= resp_data;
            end else begin
              d_ack <= 1'b1;
              d_rdata <= resp_data;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory against a transaction-level arbitration model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 0, reset = 1;
  logic i_req = 0, d_req = 0, d_we = 0, m_ack = 0;
  u32 i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic i_ack, d_ack, m_req, m_we, err;
  u32 i_rdata, d_rdata, m_addr, m_wdata;
  int checks = 0, failures = 0;
  bit busy_m = 0, resp_m = 0, own_d = 0, err_m = 0, ex_we = 0;
  int bcnt = 0, wait_m = 0, streak_m = 0, n = 0;
  u32 ex_addr = 0, ex_wdata = 0, i_rd_m = 0, d_rd_m = 0;
  int dir_wait = -1;
  bit dir_rd_en = 0, dir_i = 0, dir_d = 0, dir_we = 0;
  u32 dir_rd = 0, dir_i_addr = 0, dir_d_addr = 0, dir_wdata = 0;
  int i_raise_n = 0, i_lat = 0, i_acks = 0, d_acks = 0;
  int grants[$];
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, u32 got, u32 exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    busy_m = 0; resp_m = 0; streak_m = 0; err_m = 0; i_rd_m = 0; d_rd_m = 0;
    i_req = 0; d_req = 0; m_ack = 0;
  endtask
  task automatic step(int p_i, int p_d, int to_pct);
    u32 rd;
    @(negedge clk);
    n++;
    if (busy_m) begin
      check("m_req_busy", m_req, 1);
      check("m_addr", m_addr, ex_addr);
      check("m_we", m_we, ex_we);
      if (ex_we) check("m_wdata", m_wdata, ex_wdata);
    end else check("m_req_idle", m_req, 0);
    check("i_ack", i_ack, resp_m && !own_d);
    check("d_ack", d_ack, resp_m && own_d);
    check("i_rdata", i_rdata, i_rd_m);
    check("d_rdata", d_rdata, d_rd_m);
    check("err", err, err_m);
    if (i_ack) begin i_acks++; i_lat = n - i_raise_n; end
    if (d_ack) d_acks++;
    if (resp_m && !own_d) i_req = 0;
    else if (!i_req && (dir_i || $urandom_range(99) < p_i)) begin
      i_req = 1; i_addr = dir_i ? dir_i_addr : $urandom; dir_i = 0; i_raise_n = n;
    end
    if (resp_m && own_d) d_req = 0;
    else if (!d_req && (dir_d || $urandom_range(99) < p_d)) begin
      d_req = 1;
      d_we = dir_d ? dir_we : 1'($urandom);
      d_addr = dir_d ? dir_d_addr : $urandom;
      d_wdata = dir_d ? dir_wdata : $urandom;
      dir_d = 0;
    end
    m_ack = busy_m && bcnt == wait_m;
    m_rdata = dir_rd_en ? dir_rd : $urandom;
    if (busy_m) begin
      if (m_ack || bcnt == 255) begin
        busy_m = 0; resp_m = 1;
        rd = m_ack ? m_rdata : 32'hDEAD_BEEF;
        if (own_d) d_rd_m = rd; else i_rd_m = rd;
        if (!m_ack) err_m = 1;
      end else bcnt++;
    end else if (resp_m) resp_m = 0;
    else if (i_req || d_req) begin
      own_d = d_req && !(i_req && streak_m == 4);
      streak_m = (own_d && i_req) ? (streak_m < 4 ? streak_m + 1 : 4) : 0;
      grants.push_back(own_d);
      busy_m = 1; bcnt = 0;
      wait_m = dir_wait >= 0 ? dir_wait : ($urandom_range(99) < to_pct ? 999 : int'($urandom_range(3)));
      ex_addr = own_d ? d_addr : i_addr;
      ex_we = own_d && d_we;
      ex_wdata = d_wdata;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_m_bus", {m_we, m_addr | m_wdata}, 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    check("rst_err", err, 0);
    reset = 0;
    dir_wait = 2; dir_rd_en = 1; dir_rd = 32'h2402_0005; dir_i = 1; dir_i_addr = 32'h100; i_acks = 0;
    repeat (8) step(0, 0, 0);
    check("t1_acks", i_acks, 1);
    check("t1_lat", i_lat, 4);
    check("t1_rdata", i_rdata, 32'h2402_0005);
    dir_wait = 0; dir_rd_en = 0; grants.delete();
    dir_i = 1; dir_i_addr = 32'h300; dir_d = 1; dir_we = 1; dir_d_addr = 32'h200; dir_wdata = 32'h55;
    repeat (10) step(0, 0, 0);
    check("t2_grants", grants.size(), 2);
    if (grants.size() == 2) check("t2_order", {grants[0][0], grants[1][0]}, 2'b10);
    grants.delete();
    i_req = 0; d_req = 0;
    step(0, 0, 0);
    dir_i = 1; dir_i_addr = 32'h400;
    repeat (40) step(0, 100, 0);
    check("t3_ngrants", grants.size() >= 7, 1);
    if (grants.size() >= 7) begin
      for (int k = 0; k < 4; k++) check("t3_data", grants[k], 1);
      check("t3_instr", grants[4], 0);
      check("t3_resume", grants[5], 1);
    end
    dir_wait = -1;
    repeat (3000) step(60, 60, 0);
    dir_wait = 999; d_acks = 0;
    repeat (5) step(0, 100, 0);
    d_req = 0;
    for (int k = 0; k < 300 && d_acks == 0; k++) step(0, 0, 0);
    check("t4_abort_ack", d_acks, 1);
    check("t4_abort_data", d_rdata, 32'hDEAD_BEEF);
    dir_wait = -1;
    repeat (50) step(50, 50, 0);
    check("t4_err_sticky", err, 1);
    for (int k = 0; k < 50 && !busy_m; k++) step(100, 0, 0);
    @(negedge clk);
    reset = 1; model_reset();
    @(negedge clk);
    check("t5_m_req", m_req, 0);
    check("t5_acks", {i_ack, d_ack}, 0);
    check("t5_err", err, 0);
    reset = 0;
    dir_wait = 1; dir_i = 1; dir_i_addr = 32'h500; i_acks = 0;
    repeat (8) step(0, 0, 0);
    check("t5_refetch", i_acks, 1);
    dir_wait = -1; i_acks = 0;
    repeat (2000) step(100, 20, 3);
    check("t6_progress", i_acks > 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
